// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - round-robin scheduler sharing one PISO shift register among requesters
//
// Purpose: arbitrates NUM_REQ requesters round-robin, loads the winner's word into an
// external PISO, then lets it shift WIDTH bits MSB-first, followed by GAP idle cycles.
// Flags which PISO serial_out cycles carry frame bits and pulses done on the last one.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   req          per-requester request, held together with its word until gnt
//   data_in      requester i word at [i*WIDTH +: WIDTH]
//   gnt          one-hot 1-cycle pulse: that requester's word was taken
//   piso_load    PISO load strobe
//   piso_data    PISO parallel word
//   frame_valid  PISO serial_out carries a frame bit this cycle
//   frame_owner  requester index owning the current frame
//   busy         scheduler not idle
//   done         pulse with the last valid bit of a frame
module piso_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int GAP     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       piso_load,
  output logic [WIDTH-1:0]           piso_data,
  output logic                       frame_valid,
  output logic [$clog2(NUM_REQ)-1:0] frame_owner,
  output logic                       busy,
  output logic                       done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = 4;
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 piso_load_q, piso_load_d;
  logic [WIDTH-1:0]     piso_data_q, piso_data_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [PTR_W-1:0]     frame_owner_q, frame_owner_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 found;
  logic [PTR_W-1:0]     win;
  logic [WIDTH-1:0]     win_word;
  logic [NUM_REQ-1:0]   win_gnt;

  // Search order starts just after the last winner, so the previous owner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == (int'(ptr_q) + i) % NUM_REQ)) begin
          found = 1'b1;
          win   = PTR_W'(j);
        end
      end
    end
  end

  always_comb begin
    win_word = '0;
    win_gnt  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == PTR_W'(j)) begin
        win_word   = data_in[j*WIDTH +: WIDTH];
        win_gnt[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    gnt_d         = '0;
    piso_load_d   = 1'b0;
    piso_data_d   = piso_data_q;
    frame_owner_d = frame_owner_q;
    done_d        = 1'b0;
    // The PISO registers serial_out, so its bits trail the SHIFT state by one cycle.
    frame_valid_d = (state_q == S_SHIFT);

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d       = S_LOAD;
          gnt_d         = win_gnt;
          piso_load_d   = 1'b1;
          piso_data_d   = win_word;
          frame_owner_d = win;
          ptr_d         = win;
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        bit_cnt_d = '0;
      end
      S_SHIFT: begin
        if (bit_cnt_q == CNT_LAST) begin
          done_d    = 1'b1;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_RST;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      gnt_q         <= '0;
      piso_load_q   <= 1'b0;
      piso_data_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_owner_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      gnt_q         <= gnt_d;
      piso_load_q   <= piso_load_d;
      piso_data_q   <= piso_data_d;
      frame_valid_q <= frame_valid_d;
      frame_owner_q <= frame_owner_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign gnt         = gnt_q;
  assign piso_load   = piso_load_q;
  assign piso_data   = piso_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_owner = frame_owner_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
